// File: rtl/dvi_timing_ctrl_if.sv
// Pixel stream handshake between a pixel source and the DVI timing controller.
// A pixel moves on any cycle where pix_ready and pix_valid are both high.
interface dvi_timing_ctrl_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/dvi_timing_ctrl.sv
// DVI/VGA raster timing generator: walks h/v counters over a full frame, pulls
// pixels from the source during the active window and registers sync/colour outputs.
module dvi_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic                pxclk,
  input  logic                rst,
  input  logic                en,
  dvi_timing_ctrl_if.slave    pix,
  input  logic                clr_underflow,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                hsync,
  output logic                vsync,
  output logic                visible,
  output logic                frame_start,
  output logic                underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            visible_q, visible_d;
  logic            frame_start_q, frame_start_d;
  logic            underflow_q, underflow_d;

  logic            running;
  logic            h_last, v_last;
  logic            h_act, v_act;
  logic            h_sync_rgn, v_sync_rgn;
  logic            ready;
  logic            xfer;

  always_comb begin
    running    = (state_q == RUN);
    h_last     = (h_cnt_q == HW'(H_TOTAL - 1));
    v_last     = (v_cnt_q == VW'(V_TOTAL - 1));
    h_act      = (32'(h_cnt_q) < H_ACTIVE);
    v_act      = (32'(v_cnt_q) < V_ACTIVE);
    h_sync_rgn = (32'(h_cnt_q) >= H_SYNC_START) && (32'(h_cnt_q) < H_SYNC_START + H_SYNC);
    v_sync_rgn = (32'(v_cnt_q) >= V_SYNC_START) && (32'(v_cnt_q) < V_SYNC_START + V_SYNC);
    ready      = running && h_act && v_act;
    xfer       = ready && pix.pix_valid;
  end

  assign pix.pix_ready = ready;

  // en is only looked at on the last pixel of a frame so a frame is never cut short.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_cnt_d = '0;
          if (v_last) begin
            v_cnt_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            v_cnt_d = v_cnt_q + VW'(1);
          end
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  // All outputs are one register stage behind the counters, so they stay aligned.
  always_comb begin
    visible_d     = ready;
    hsync_d       = (running && h_sync_rgn) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (running && v_sync_rgn) ? SYNC_POL : ~SYNC_POL;
    rgb_d         = xfer ? pix.pix_data : 24'h0;
    frame_start_d = ready && (h_cnt_q == '0) && (v_cnt_q == '0);
    // A new starvation event wins over a simultaneous clear.
    underflow_d   = (ready && !pix.pix_valid) || (underflow_q && !clr_underflow);
  end

  always_ff @(posedge pxclk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= 24'h0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      visible_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl on a tiny 8x5 raster, checked cycle by cycle against
// a model that tracks the frame as one linear pixel position.
module tb_dvi_timing_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [29:0] IDLE_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  logic        pxclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, visible, frame_start, underflow;

  int n_cmp = 0;
  int n_fail = 0;

  dvi_timing_ctrl_if pix_if();

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .pxclk(pxclk),
    .rst(rst_n),
    .en(en),
    .pix(pix_if.slave),
    .clr_underflow(clr),
    .red(red),
    .green(green),
    .blue(blue),
    .hsync(hsync),
    .vsync(vsync),
    .visible(visible),
    .frame_start(frame_start),
    .underflow(underflow)
  );

  always #5 pxclk = ~pxclk;

  // Reference model: position 0..FT-1 within the frame, plus a running flag.
  bit          m_run;
  int          m_pos;
  logic        e_vis, e_hs, e_vs, e_fs, e_uf;
  logic [23:0] e_rgb;

  function automatic logic m_ready(bit run, int p);
    return run && ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic logic in_hsync(int p);
    return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
  endfunction

  function automatic logic in_vsync(int p);
    return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
  endfunction

  always @(posedge pxclk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pos <= 0;
      e_vis <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1;
      e_fs <= 1'b0; e_uf <= 1'b0; e_rgb <= 24'h0;
    end else begin
      e_vis <= m_ready(m_run, m_pos);
      e_hs  <= ~(m_run && in_hsync(m_pos));
      e_vs  <= ~(m_run && in_vsync(m_pos));
      e_fs  <= m_ready(m_run, m_pos) && (m_pos == 0);
      e_rgb <= (m_ready(m_run, m_pos) && pix_if.pix_valid) ? pix_if.pix_data : 24'h0;
      e_uf  <= (m_ready(m_run, m_pos) && !pix_if.pix_valid) || (e_uf && !clr);
      if (!m_run) begin
        m_pos <= 0;
        if (en) m_run <= 1'b1;
      end else if (m_pos == FT - 1) begin
        m_pos <= 0;
        if (!en) m_run <= 1'b0;
      end else begin
        m_pos <= m_pos + 1;
      end
    end
  end

  function automatic logic [29:0] dut_vec();
    return {pix_if.pix_ready, visible, hsync, vsync, frame_start, underflow, red, green, blue};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {m_ready(m_run, m_pos), e_vis, e_hs, e_vs, e_fs, e_uf, e_rgb};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    pix_if.pix_valid = 1'b1; pix_if.pix_data = 24'h0;
    repeat (3) begin
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== IDLE_VEC) begin
        n_fail++;
        $display("FAIL reset_state: got %h want %h", dut_vec(), IDLE_VEC);
      end
    end
    rst_n = 1'b1;
    @(negedge pxclk);
    n_cmp++;
    if (dut_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL idle_no_en: got %h want %h", dut_vec(), IDLE_VEC);
    end
  endtask

  task automatic test_stream();
    int last_fs = -1;
    logic [23:0] data = 24'h000001;
    en = 1'b1; pix_if.pix_valid = 1'b1; pix_if.pix_data = data;
    for (int i = 0; i < 3 * FT + 5; i++) begin
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (i - last_fs !== FT) begin
            n_fail++;
            $display("FAIL frame_period: got %0d want %0d", i - last_fs, FT);
          end
        end
        last_fs = i;
      end
      data = data + 24'h010203;
      pix_if.pix_data = data;
    end
    n_cmp++;
    if (last_fs < 0) begin
      n_fail++;
      $display("FAIL frame_start_seen: got none want pulse");
    end
  endtask

  task automatic test_underflow();
    int k = 0;
    clr = 1'b1;
    @(negedge pxclk);
    clr = 1'b0;
    while (!m_ready(m_run, m_pos) && k < 100) begin
      @(negedge pxclk); k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL uf_wait_ready: got timeout want ready");
    end
    pix_if.pix_valid = 1'b0; pix_if.pix_data = 24'hABCDEF;
    @(negedge pxclk);
    pix_if.pix_valid = 1'b1;
    n_cmp++;
    if ({underflow, red, green, blue} !== {1'b1, 24'h0}) begin
      n_fail++;
      $display("FAIL starved_pixel: got uf=%b rgb=%h want uf=1 rgb=000000", underflow, {red, green, blue});
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== exp_vec() || underflow !== 1'b1) begin
        n_fail++;
        $display("FAIL uf_sticky cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    clr = 1'b1;
    @(negedge pxclk);
    clr = 1'b0;
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_clear: got %b want 0", underflow);
    end
  endtask

  task automatic test_simul_clear();
    int k = 0;
    while (!m_ready(m_run, m_pos) && k < 100) begin
      @(negedge pxclk); k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL sc_wait_ready: got timeout want ready");
    end
    pix_if.pix_valid = 1'b0; clr = 1'b1;
    @(negedge pxclk);
    pix_if.pix_valid = 1'b1; clr = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clear: got %b want 1", underflow);
    end
    clr = 1'b1;
    @(negedge pxclk);
    clr = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      pix_if.pix_valid = ($urandom_range(0, 7) != 0);
      pix_if.pix_data  = 24'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    clr = 1'b0; pix_if.pix_valid = 1'b1;
  endtask

  task automatic test_en_drop();
    int k = 0;
    en = 1'b1;
    while (!(m_run && m_pos == 12) && k < 200) begin
      @(negedge pxclk); k++;
    end
    n_cmp++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL drop_wait_pos12: got timeout want pos 12");
    end
    en = 1'b0;
    for (int i = 0; i < FT; i++) begin
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL en_drop cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge pxclk);
      n_cmp++;
      if ({pix_if.pix_ready, hsync, vsync, visible} !== 4'b0110) begin
        n_fail++;
        $display("FAIL idle_after_drop: got rdy/hs/vs/vis=%b want 0110",
                 {pix_if.pix_ready, hsync, vsync, visible});
      end
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    en = 1'b1; pix_if.pix_valid = 1'b1; pix_if.pix_data = 24'h123456;
    while (!(m_run && m_pos == HT + 2) && k < 200) begin
      @(negedge pxclk); k++;
    end
    n_cmp++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL ar_wait_pos: got timeout want h=2 v=1");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), IDLE_VEC);
    end
    @(negedge pxclk);
    @(negedge pxclk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge pxclk);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL restart cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 1) begin
        n_cmp++;
        if (frame_start !== 1'b1) begin
          n_fail++;
          $display("FAIL restart_frame_start: got %b want 1", frame_start);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow();
    test_simul_clear();
    test_random();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_timing_ctrl.md
DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 Parameter H_FP, 16: horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96: horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48: horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical equivalents, in lines.
REQ-006 Parameter SYNC_POL, 0: asserted level of hsync/vsync; the inactive level is ~SYNC_POL.
REQ-007 pxclk  in  1  pixel clock; the only clock; all state on its rising edge.
REQ-008 rst  in  1  reset, asynchronous assert, active-low.
REQ-009 en  in  1  run request.
REQ-010 pix_data  in  24  {red, green, blue} from pixel source.
REQ-011 pix_valid  in  1  pix_data valid.
REQ-012 pix_ready  out  1  controller consumes pix_data this cycle.
REQ-013 red, green, blue  out  8 each  pixel to channel coder.
REQ-014 hsync, vsync, visible  out  1 each  timing to channel coder.
REQ-015 frame_start  out  1  one-cycle pulse with first pixel of frame.
REQ-016 underflow  out  1  sticky starvation flag.
REQ-017 clr_underflow  in  1  clears underflow.

Function
REQ-018 The block SHALL implement a two-state FSM, IDLE and RUN, plus counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1), with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL computed likewise; counter widths SHALL be clog2 of the totals.
REQ-019 IDLE->RUN SHALL occur on the first cycle en=1; counters are 0 on entry.
REQ-020 In RUN, h_cnt SHALL increment every cycle and wrap to 0 after H_TOTAL-1.
REQ-021 v_cnt SHALL increment on h_cnt wrap and wrap to 0 after V_TOTAL-1.
REQ-022 en SHALL be sampled only at frame wrap (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1); en=0 there -> IDLE with counters 0, so frames are never truncated.
REQ-023 Horizontal regions: active h_cnt<H_ACTIVE, front porch next H_FP, sync next H_SYNC, back porch remainder; vertical regions are defined likewise on v_cnt.
REQ-024 pix_ready SHALL be combinational, high iff RUN and h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; a transfer occurs on pix_ready&pix_valid.
REQ-025 All timing and pixel outputs SHALL be registered with latency exactly 1 cycle from the counter state that produced them, so hsync, vsync, visible and the colours are mutually aligned.
REQ-026 visible SHALL equal the registered pix_ready.
REQ-027 hsync SHALL be SYNC_POL in the horizontal sync region, else ~SYNC_POL; vsync SHALL be SYNC_POL in the vertical sync region (all h_cnt), else ~SYNC_POL.
REQ-028 Colours SHALL be the registered pix_data on a transfer, else 0.
REQ-029 pix_ready=1 with pix_valid=0 SHALL drive 0 on the colour outputs for that pixel and set underflow the next cycle; there are no retries and timing never stalls.
REQ-030 underflow SHALL clear on clr_underflow=1; a simultaneous set and clear SHALL leave underflow=1.
REQ-031 frame_start SHALL be 1 for exactly the cycle in which visible is 1 for pixel (0,0).
REQ-032 In IDLE: pix_ready=0, visible=0, frame_start=0, colours=0, hsync=vsync=~SYNC_POL.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, h_cnt=v_cnt=0, all outputs to the REQ-032 values, and underflow=0, including mid-frame.
REQ-034 After rst rises, the block SHALL behave as REQ-019 on the first clock edge with en=1.

Verification (use H 4/1/2/1, V 2/1/1/1, SYNC_POL=0: H_TOTAL=8, V_TOTAL=5)
REQ-035 en=1, pix_valid=1 constant, data=incrementing -> per line the visible pattern is 11110000 delayed 1 cycle, hsync is 0 on cycles 5-6 of each line, vsync is 0 on line 3, frame_start recurs every 40 cycles.
REQ-036 pix_valid=0 for one active cycle -> the matching output pixel is 000000, underflow=1 the next cycle and stays 1 until clr_underflow=1.
REQ-037 en dropped mid-frame (cycle 12) -> the frame completes through cycle 39, then IDLE with hsync=vsync=1, pix_ready=0.
REQ-038 rst=0 asserted asynchronously at h_cnt=2, v_cnt=1 -> outputs go to IDLE values before the next edge; en=1 after release restarts at (0,0) with frame_start.
REQ-039 clr_underflow=1 in the same cycle as a new starvation event -> underflow remains 1.
